dmem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port data memory between the `NUM_CORES` pipelines of the multicore processor. It sits between each core's MEM stage and the data memory. It grants at most one access per cycle, routes read data back to the requesting core one cycle later, and drives a per-core stall that the core ORs into its pipeline stall alongside `ID_stall`. Accesses are pipelined, so a new grant can issue in the same cycle as a previous read's response.

---
 rtl/dmem_arbiter_pkg.sv | 12 +
 rtl/dmem_arbiter_rr_priority.sv | 53 +++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: core-count limit and
// the index-width helper used by the arbiter and its priority search.
package arb_defs;

  localparam int NUM_CORES_MAX = 8;

  // Index width for n requesters, never below one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_priority.sv
// Combinational round-robin search: the first set request at or after ptr,
// wrapping modulo N, found by scanning a doubled copy of the request vector.
module rr_priority
  import arb_defs::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gidx,
  output logic             any
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W:0]   base;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  assign dbl  = {req, req};
  assign base = {1'b0, ptr};

  // rot[k] is the request k positions after ptr.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign rot[gi] = dbl[base + (IDX_W+1)'(gi)];
    end
  endgenerate

  always_comb begin
    any = 1'b0;
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        off = IDX_W'(k);
      end
    end
  end

  assign sum  = base + {1'b0, off};
  assign gidx = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : IDX_W'(sum);

  generate
    for (gi = 0; gi < N; gi++) begin : g_gnt
      assign gnt[gi] = any & (gidx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of one single-port data memory between NUM_CORES
// pipelines: one access per cycle, read data returned the following cycle.
module dmem_arbiter
  import arb_defs::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES-1:0]          core_half,
  input  logic [NUM_CORES-1:0]          core_byte,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_stall,
  output logic [NUM_CORES*DATA_W-1:0]   core_rdata,
  output logic [NUM_CORES-1:0]          core_rvalid,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic                          mem_half,
  output logic                          mem_byte,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int IDX_W = idx_w(NUM_CORES);

  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic [NUM_CORES-1:0] rd_pend_reg, rd_pend_next;
  logic [IDX_W-1:0]     rsp_idx_reg, rsp_idx_next;
  logic                 rsp_valid_reg, rsp_valid_next;

  logic [NUM_CORES-1:0] req_live;
  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] gnt;
  logic [IDX_W-1:0]     gidx;
  logic                 any;
  logic                 rsp_live;
  logic [IDX_W:0]       gidx_inc;

  // Requests and a pending response are ignored while Reset is high, so
  // every output is quiet during reset and an in-flight read is dropped.
  assign req_live = Reset ? '0 : core_req;
  assign rsp_live = rsp_valid_reg & ~Reset;
  assign elig     = req_live & ~rd_pend_reg;

  rr_priority #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_rr (
    .req  (elig),
    .ptr  (ptr_reg),
    .gnt  (gnt),
    .gidx (gidx),
    .any  (any)
  );

  always_comb begin
    mem_en    = any;
    mem_we    = 1'b0;
    mem_half  = 1'b0;
    mem_byte  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt[i]) begin
        mem_we    = core_we[i];
        mem_half  = core_half[i];
        mem_byte  = core_byte[i];
        mem_addr  = core_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_rsp
      assign core_rvalid[gi]                   = rsp_live & (rsp_idx_reg == IDX_W'(gi));
      assign core_rdata[gi*DATA_W +: DATA_W]   = core_rvalid[gi] ? mem_rdata : '0;
    end
  endgenerate

  // A read grant still stalls; the core is released on its data pulse.
  assign core_stall = req_live & ~(gnt & core_we) & ~core_rvalid;

  always_comb begin
    gidx_inc       = {1'b0, gidx} + (IDX_W+1)'(1);
    ptr_next       = ptr_reg;
    rsp_idx_next   = rsp_idx_reg;
    rsp_valid_next = any & ~mem_we;
    rd_pend_next   = (rd_pend_reg & ~core_rvalid) | (gnt & ~core_we);
    if (any) begin
      ptr_next = (gidx_inc == (IDX_W+1)'(NUM_CORES)) ? '0 : IDX_W'(gidx_inc);
      if (!mem_we) begin
        rsp_idx_next = gidx;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_reg       <= '0;
      rd_pend_reg   <= '0;
      rsp_idx_reg   <= '0;
      rsp_valid_reg <= 1'b0;
    end else begin
      ptr_reg       <= ptr_next;
      rd_pend_reg   <= rd_pend_next;
      rsp_idx_reg   <= rsp_idx_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a ROM-style memory model, a scoreboard of
// expected read responses and immediate-assertion checks at each step.
module tb_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [N-1:0]    core_req, core_we, core_half, core_byte;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_stall;
  logic [N*DW-1:0] core_rdata;
  logic [N-1:0]    core_rvalid;
  logic            mem_en, mem_we, mem_half, mem_byte;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  typedef struct {
    int          cyc;
    int          core;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   cur      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_half   (core_half),
    .core_byte   (core_byte),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_stall  (core_stall),
    .core_rdata  (core_rdata),
    .core_rvalid (core_rvalid),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_half    (mem_half),
    .mem_byte    (mem_byte),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge Clk) begin
    if (mem_en && !mem_we) mem_rdata <= rom(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    logic [N-1:0]    exp_v;
    logic [N*DW-1:0] exp_d;
    exp_v = '0;
    exp_d = '0;
    if (sb.size() > 0 && sb[0].cyc == cur) begin
      exp_v[sb[0].core]              = 1'b1;
      exp_d[sb[0].core*DW +: DW]     = sb[0].data;
      $display("rsp   cycle %0d core %0d data %h", cur, sb[0].core, sb[0].data);
      void'(sb.pop_front());
    end
    chk("rvalid", 32'(core_rvalid), 32'(exp_v));
    n_assert++;
    assert (core_rdata === exp_d) else begin
      n_fail++;
      $error("FAIL rdata observed=%h expected=%h", core_rdata, exp_d);
    end
  endtask

  task automatic set_core(input int i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic half, input logic byt);
    core_req[i]              = 1'b1;
    core_we[i]               = we;
    core_half[i]             = half;
    core_byte[i]             = byt;
    core_addr[i*AW +: AW]    = addr;
    core_wdata[i*DW +: DW]   = wd;
    $display("drive cycle %0d core %0d %s addr %h wdata %h", cur, i, we ? "W" : "R", addr, wd);
  endtask

  task automatic clr_core(input int i);
    core_req[i]            = 1'b0;
    core_we[i]             = 1'b0;
    core_half[i]           = 1'b0;
    core_byte[i]           = 1'b0;
    core_addr[i*AW +: AW]  = '0;
    core_wdata[i*DW +: DW] = '0;
  endtask

  task automatic expect_read(input int core, input logic [31:0] addr);
    rsp_t r;
    r.cyc  = cur + 1;
    r.core = core;
    r.data = rom(addr);
    sb.push_back(r);
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
    cur++;
  endtask

  task automatic smp();
    @(negedge Clk);
    check_rsp();
  endtask

  initial begin
    logic [N-1:0] mask;
    Reset      = 1'b1;
    core_req   = '0;
    core_we    = '0;
    core_half  = '0;
    core_byte  = '0;
    core_addr  = '0;
    core_wdata = '0;

    // Reset state
    nxt();
    nxt();
    smp();
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    nxt();
    Reset = 1'b0;
    smp();
    chk("post_rst_mem_en", 32'(mem_en), 32'd0);

    // Single read by core 2
    nxt();
    set_core(2, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
    expect_read(2, 32'h40);
    smp();
    chk("rd_mem_en", 32'(mem_en), 32'd1);
    chk("rd_addr", mem_addr, 32'h40);
    chk("rd_we", 32'(mem_we), 32'd0);
    chk("rd_stall_c0", 32'(core_stall), 32'b0100);
    nxt();
    smp();
    chk("rd_stall_c1", 32'(core_stall), 32'd0);
    chk("rd_masked", 32'(mem_en), 32'd0);
    nxt();
    clr_core(2);
    smp();
    chk("rd_idle", 32'(mem_en), 32'd0);

    // Reset asserted the cycle after a core 3 read grant
    nxt();
    set_core(3, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0);
    smp();
    chk("rr_gnt_en", 32'(mem_en), 32'd1);
    chk("rr_gnt_addr", mem_addr, 32'h80);
    chk("rr_stall", 32'(core_stall), 32'b1000);
    nxt();
    Reset = 1'b1;
    clr_core(3);
    smp();
    chk("rr_mem_en", 32'(mem_en), 32'd0);
    chk("rr_stall_rst", 32'(core_stall), 32'd0);
    chk("rr_addr", mem_addr, 32'd0);
    nxt();
    Reset = 1'b0;
    smp();
    chk("rr_after_en", 32'(mem_en), 32'd0);
    chk("rr_after_rvalid", 32'(core_rvalid), 32'd0);

    // Full contention: all four cores write
    nxt();
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 32'h200 + 32'(4*i), 32'h1111_0000 + 32'(i), 1'b0, 1'b0);
    mask = '1;
    for (int k = 0; k < N; k++) begin
      smp();
      chk("ct_en", 32'(mem_en), 32'd1);
      chk("ct_we", 32'(mem_we), 32'd1);
      chk("ct_addr", mem_addr, 32'h200 + 32'(4*k));
      chk("ct_wdata", mem_wdata, 32'h1111_0000 + 32'(k));
      chk("ct_stall", 32'(core_stall), 32'(mask & ~(4'b0001 << k)));
      nxt();
      clr_core(k);
      mask[k] = 1'b0;
    end
    smp();
    chk("ct_idle", 32'(mem_en), 32'd0);

    // Overlapped: core 0 read and core 1 write together (ptr back at 0)
    nxt();
    set_core(0, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0);
    set_core(1, 1'b1, 32'h204, 32'h5555_AAAA, 1'b0, 1'b0);
    expect_read(0, 32'h44);
    smp();
    chk("ov_c0_en", 32'(mem_en), 32'd1);
    chk("ov_c0_addr", mem_addr, 32'h44);
    chk("ov_c0_we", 32'(mem_we), 32'd0);
    chk("ov_c0_stall", 32'(core_stall), 32'b0011);
    nxt();
    smp();
    chk("ov_c1_en", 32'(mem_en), 32'd1);
    chk("ov_c1_we", 32'(mem_we), 32'd1);
    chk("ov_c1_addr", mem_addr, 32'h204);
    chk("ov_c1_stall", 32'(core_stall), 32'd0);
    nxt();
    clr_core(0);
    clr_core(1);
    smp();
    chk("ov_idle", 32'(mem_en), 32'd0);

    // Repeated reads from core 1: one grant every other cycle
    for (int k = 0; k < 4; k++) begin
      nxt();
      set_core(1, 1'b0, 32'h60 + 32'(4*k), 32'h0, 1'b0, 1'b0);
      expect_read(1, 32'h60 + 32'(4*k));
      smp();
      chk("rep_en", 32'(mem_en), 32'd1);
      chk("rep_addr", mem_addr, 32'h60 + 32'(4*k));
      chk("rep_stall", 32'(core_stall), 32'b0010);
      nxt();
      smp();
      chk("rep_no_regrant", 32'(mem_en), 32'd0);
      chk("rep_release", 32'(core_stall), 32'd0);
    end
    nxt();
    clr_core(1);
    smp();
    chk("rep_idle", 32'(mem_en), 32'd0);

    // Sub-word: store byte and load half
    nxt();
    set_core(0, 1'b1, 32'h103, 32'h0000_00AB, 1'b0, 1'b1);
    smp();
    chk("sb_byte", 32'(mem_byte), 32'd1);
    chk("sb_half", 32'(mem_half), 32'd0);
    chk("sb_addr", mem_addr, 32'h103);
    chk("sb_we", 32'(mem_we), 32'd1);
    chk("sb_wdata", mem_wdata, 32'h0000_00AB);
    chk("sb_stall", 32'(core_stall), 32'd0);
    nxt();
    clr_core(0);
    set_core(2, 1'b0, 32'h52, 32'h0, 1'b1, 1'b0);
    expect_read(2, 32'h52);
    smp();
    chk("lh_half", 32'(mem_half), 32'd1);
    chk("lh_byte", 32'(mem_byte), 32'd0);
    chk("lh_addr", mem_addr, 32'h52);
    nxt();
    smp();
    nxt();
    clr_core(2);
    smp();
    chk("end_idle", 32'(mem_en), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
